// File: rtl/mdu_ctrl_if.sv
// Handshake and mac bus bundle for the M-extension issue stage.
// Carries request, mac operand/result and response signals.
interface mdu_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_funct3;
  logic        in_word;
  logic [63:0] in_src1;
  logic [63:0] in_src2;
  logic [7:0]  mac_op;
  logic [63:0] mac_src1;
  logic [63:0] mac_src2;
  logic [63:0] mac_result;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_result;

  modport slave (
    input  in_valid, in_funct3, in_word,
    input  in_src1, in_src2,
    input  mac_result, out_ready,
    output in_ready, mac_op,
    output mac_src1, mac_src2,
    output out_valid, out_result
  );

  modport master (
    output in_valid, in_funct3, in_word,
    output in_src1, in_src2,
    output mac_result, out_ready,
    input  in_ready, mac_op,
    input  mac_src1, mac_src2,
    input  out_valid, out_result
  );
endinterface

// File: rtl/mdu_ctrl.sv
// RV64M issue/sequencing stage in front of a combinational mac.
// Ports: clock, reset (async high), bus (mdu_ctrl_if.slave).
// Define MDU_BYPASS_EN to retire override/illegal ops in 1 cycle.
module mdu_ctrl #(
  parameter int LATENCY = 2
) (
  input logic     clock,
  input logic     reset,
  mdu_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  localparam logic [1:0] OV_NONE = 2'd0;
  localparam logic [1:0] OV_DZ   = 2'd1;
  localparam logic [1:0] OV_OVF  = 2'd2;
  localparam logic [1:0] OV_ILL  = 2'd3;

  localparam int CW =
    (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(LATENCY - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    op_q, op_d;
  logic [63:0]   src1_q, src1_d;
  logic [63:0]   src2_q, src2_d;
  logic          vld_q, vld_d;
  logic [63:0]   res_q, res_d;
  logic [1:0]    code_q, code_d;
  logic          rem_q, rem_d;
  logic          word_q, word_d;

  logic [2:0]  f3;
  logic        w;
  logic        ill;
  logic        sx;
  logic        zx;
  logic [63:0] s1p;
  logic [63:0] s2p;
  logic        dz;
  logic        ovf;
  logic [1:0]  ovr;
  logic [7:0]  op_dec;
  logic        skip;

  assign f3 = bus.in_funct3;
  assign w  = bus.in_word;

  // MULHW/MULHSUW/MULHUW do not exist.
  assign ill = w & ~f3[2] & (f3[1:0] != 2'd0);
  assign sx  = w & ~f3[0] & ~ill;
  assign zx  = w & f3[2] & f3[0];

  always_comb begin
    s1p = bus.in_src1;
    s2p = bus.in_src2;
    if (sx) begin
      s1p = {{32{bus.in_src1[31]}}, bus.in_src1[31:0]};
      s2p = {{32{bus.in_src2[31]}}, bus.in_src2[31:0]};
    end else if (zx) begin
      s1p = {32'd0, bus.in_src1[31:0]};
      s2p = {32'd0, bus.in_src2[31:0]};
    end
  end

  // Operands are already extended, so the full
  // 64-bit compare covers the W divisor too.
  assign dz = f3[2] & (s2p == 64'd0);

  always_comb begin
    ovf = 1'b0;
    if (f3[2] & ~f3[0]) begin
      if (w)
        ovf = (s1p[31:0] == 32'h8000_0000) &
              (s2p[31:0] == 32'hFFFF_FFFF);
      else
        ovf = (s1p == {1'b1, 63'd0}) &
              (s2p == '1);
    end
  end

  always_comb begin
    ovr = OV_NONE;
    unique case (1'b1)
      ill:     ovr = OV_ILL;
      dz:      ovr = OV_DZ;
      ovf:     ovr = OV_OVF;
      default: ovr = OV_NONE;
    endcase
  end

  always_comb begin
    op_dec = 8'd0;
    case (f3)
      3'd0: op_dec = 8'h80;
      3'd1: op_dec = 8'h40;
      3'd2: op_dec = 8'h10;
      3'd3: op_dec = 8'h20;
      3'd4: op_dec = 8'h08;
      3'd5: op_dec = 8'h04;
      3'd6: op_dec = 8'h02;
      default: op_dec = 8'h01;
    endcase
  end

`ifdef MDU_BYPASS_EN
  assign skip = (ovr != OV_NONE);
`else
  assign skip = 1'b0;
`endif

  function automatic logic [63:0] fin(
    input logic [1:0]  code,
    input logic        rem,
    input logic        word,
    input logic [63:0] dvd,
    input logic [63:0] mres
  );
    logic [63:0] r;
    case (code)
      OV_NONE: r = mres;
      OV_DZ:   r = rem ? dvd : '1;
      OV_OVF:  r = rem ? 64'd0 : dvd;
      default: r = 64'd0;
    endcase
    if (word)
      r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    vld_d   = vld_q;
    res_d   = res_q;
    code_d  = code_q;
    rem_d   = rem_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          code_d = ovr;
          rem_d  = f3[1];
          word_d = w;
          src1_d = s1p;
          src2_d = s2p;
          cnt_d  = '0;
          if (skip) begin
            state_d = DONE;
            vld_d   = 1'b1;
            op_d    = 8'd0;
            res_d   = fin(ovr, f3[1], w,
                          s1p, 64'd0);
          end else begin
            state_d = BUSY;
            op_d    = ill ? 8'd0 : op_dec;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          op_d    = 8'd0;
          vld_d   = 1'b1;
          res_d   = fin(code_q, rem_q, word_q,
                        src1_q, bus.mac_result);
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      vld_q   <= 1'b0;
      res_q   <= '0;
      code_q  <= OV_NONE;
      rem_q   <= 1'b0;
      word_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      vld_q   <= vld_d;
      res_q   <= res_d;
      code_q  <= code_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE) & ~reset;
  assign bus.mac_op     = op_q;
  assign bus.mac_src1   = src1_q;
  assign bus.mac_src2   = src2_q;
  assign bus.out_valid  = vld_q;
  assign bus.out_result = res_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl with a behavioural mac.
// Checks results, latency, backpressure and reset abort.
module tb_mdu_ctrl;
  localparam int LAT = 2;

  logic clk;
  logic rst;
  int   vec_cnt;
  int   err_cnt;
  logic [63:0] sb[$];

  mdu_ctrl_if bus();

  mdu_ctrl #(.LATENCY(LAT)) dut (
    .clock(clk),
    .reset(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Raw 64-bit arithmetic; corner cases give junk
  // so the DUT override path is exercised.
  function automatic logic [63:0] arith(
    input logic [2:0]  f,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [127:0] p;
    logic [63:0]  r;
    logic         ov;
    ov = (a == {1'b1, 63'd0}) && (b == '1);
    r  = 64'hDEAD_BEEF_DEAD_BEEF;
    case (f)
      3'd0: r = a * b;
      3'd1: begin
        p = $signed({{64{a[63]}}, a}) *
            $signed({{64{b[63]}}, b});
        r = p[127:64];
      end
      3'd2: begin
        p = $signed({{64{a[63]}}, a}) *
            $signed({64'd0, b});
        r = p[127:64];
      end
      3'd3: begin
        p = {64'd0, a} * {64'd0, b};
        r = p[127:64];
      end
      3'd4:
        if (b != 0 && !ov)
          r = $signed(a) / $signed(b);
      3'd5: if (b != 0) r = a / b;
      3'd6:
        if (b != 0 && !ov)
          r = $signed(a) % $signed(b);
      default: if (b != 0) r = a % b;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] mac_model(
    input logic [7:0]  op,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (op)
      8'h00: return 64'd0;
      8'h80: return arith(3'd0, a, b);
      8'h40: return arith(3'd1, a, b);
      8'h10: return arith(3'd2, a, b);
      8'h20: return arith(3'd3, a, b);
      8'h08: return arith(3'd4, a, b);
      8'h04: return arith(3'd5, a, b);
      8'h02: return arith(3'd6, a, b);
      8'h01: return arith(3'd7, a, b);
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  always_comb
    bus.mac_result = mac_model(bus.mac_op,
                               bus.mac_src1,
                               bus.mac_src2);

  function automatic logic [63:0] ref_res(
    input logic [2:0]  f,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [31:0] a32, b32, r32;
    logic        ov;
    if (!w) begin
      ov = (a == {1'b1, 63'd0}) && (b == '1);
      if (f[2] && b == 0)
        return f[1] ? a : '1;
      if ((f == 3'd4 || f == 3'd6) && ov)
        return f[1] ? 64'd0 : a;
      return arith(f, a, b);
    end
    a32 = a[31:0];
    b32 = b[31:0];
    ov  = (a32 == 32'h8000_0000) &&
          (b32 == 32'hFFFF_FFFF);
    r32 = 32'd0;
    case (f)
      3'd0: r32 = a32 * b32;
      3'd4:
        if (b32 == 0) r32 = '1;
        else if (ov) r32 = a32;
        else r32 = $signed(a32) / $signed(b32);
      3'd5:
        if (b32 == 0) r32 = '1;
        else r32 = a32 / b32;
      3'd6:
        if (b32 == 0) r32 = a32;
        else if (ov) r32 = 32'd0;
        else r32 = $signed(a32) % $signed(b32);
      3'd7:
        if (b32 == 0) r32 = a32;
        else r32 = a32 % b32;
      default: r32 = 32'd0;
    endcase
    return {{32{r32[31]}}, r32};
  endfunction

  function automatic logic special(
    input logic [2:0]  f,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
    if (w && !f[2] && f != 3'd0) return 1'b1;
    if (!f[2]) return 1'b0;
    if (w) begin
      if (b[31:0] == 0) return 1'b1;
      return !f[0] &&
             a[31:0] == 32'h8000_0000 &&
             b[31:0] == 32'hFFFF_FFFF;
    end
    if (b == 0) return 1'b1;
    return !f[0] && a == {1'b1, 63'd0} &&
           b == '1;
  endfunction

  function automatic logic [7:0] exp_op(
    input logic [2:0]  f,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
    logic [7:0] tbl [8];
    tbl = '{8'h80, 8'h40, 8'h10, 8'h20,
            8'h08, 8'h04, 8'h02, 8'h01};
    if (w && !f[2] && f != 3'd0) return 8'd0;
`ifdef MDU_BYPASS_EN
    if (special(f, w, a, b)) return 8'd0;
`endif
    return tbl[f];
  endfunction

  function automatic int exp_lat(
    input logic [2:0]  f,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b
  );
`ifdef MDU_BYPASS_EN
    if (special(f, w, a, b)) return 1;
`endif
    return LAT + 1;
  endfunction

  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0)
        check("sb_underflow", 64'(sb.size()), 64'd1);
      else
        check("result", bus.out_result,
              sb.pop_front());
    end
  end

  task automatic run_op(
    input logic [2:0]  f,
    input logic        w,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] exp,
    input int          hold
  );
    int          n;
    logic [63:0] r0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = f;
    bus.in_word   = w;
    bus.in_src1   = a;
    bus.in_src2   = b;
    check("in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(exp);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("mac_op", 64'(bus.mac_op),
          64'(exp_op(f, w, a, b)));
    n = 1;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    check("latency", 64'(n),
          64'(exp_lat(f, w, a, b)));
    if (!bus.out_valid) begin
      void'(sb.pop_back());
      return;
    end
    r0 = bus.out_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_valid", 64'(bus.out_valid), 64'd1);
      check("bp_result", bus.out_result, r0);
      check("bp_in_ready", 64'(bus.in_ready), 64'd0);
      check("bp_mac_op", 64'(bus.mac_op), 64'd0);
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    check("post_valid", 64'(bus.out_valid), 64'd0);
    check("post_ready", 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f;
    logic        w;
    logic [63:0] a, b;
    vec_cnt       = 0;
    err_cnt       = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_funct3 = 3'd0;
    bus.in_word   = 1'b0;
    bus.in_src1   = 64'd0;
    bus.in_src2   = 64'd0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_result", bus.out_result, 64'd0);
    check("rst_mac_op", 64'(bus.mac_op), 64'd0);
    check("rst_src1", bus.mac_src1, 64'd0);
    check("rst_src2", bus.mac_src2, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rel_in_ready", 64'(bus.in_ready), 64'd1);

    run_op(3'd0, 0, 64'd7, -64'sd3,
           64'hFFFF_FFFF_FFFF_FFEB, 5);
    run_op(3'd1, 0, {1'b1, 63'd0}, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd3, 0, {1'b1, 63'd0}, 64'd2,
           64'd1, 0);
    run_op(3'd4, 0, 64'd10, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op(3'd7, 0, 64'd10, 64'd0,
           64'd10, 0);
    run_op(3'd5, 1, 64'h1_8000_0000, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd4, 0, {1'b1, 63'd0}, '1,
           {1'b1, 63'd0}, 0);
    run_op(3'd6, 0, {1'b1, 63'd0}, '1,
           64'd0, 0);
    run_op(3'd4, 1, 64'h8000_0000,
           64'hFFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 0);
    run_op(3'd1, 1, 64'd5, 64'd3, 64'd0, 0);
    run_op(3'd2, 0, '1, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 0);
    run_op(3'd0, 1, 64'h1_7FFF_FFFF, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFE, 0);
    run_op(3'd6, 1, 64'hFFFF_FFFF_FFFF_FFF9,
           64'd2, '1, 0);
    run_op(3'd5, 0, 64'd100, 64'd7, 64'd14, 0);

    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      w = 1'($urandom_range(0, 1));
      a = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: b = 64'd0;
        1: b = 64'($urandom_range(1, 9));
        2: b = '1;
        default: b = {$urandom, $urandom};
      endcase
      run_op(f, w, a, b, ref_res(f, w, a, b),
             int'($urandom_range(0, 2)));
    end

    // Abort a multiply while it is counting.
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_funct3 = 3'd0;
    bus.in_word   = 1'b0;
    bus.in_src1   = 64'd3;
    bus.in_src2   = 64'd4;
    @(posedge clk);
    sb.push_back(64'd12);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("busy_mac_op", 64'(bus.mac_op), 64'h80);
    #2 rst = 1'b1;
    #1;
    check("abt_in_ready", 64'(bus.in_ready), 64'd0);
    check("abt_valid", 64'(bus.out_valid), 64'd0);
    check("abt_result", bus.out_result, 64'd0);
    check("abt_mac_op", 64'(bus.mac_op), 64'd0);
    check("abt_src1", bus.mac_src1, 64'd0);
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abt_rel_ready", 64'(bus.in_ready), 64'd1);
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      check("abt_stray", 64'(bus.out_valid), 64'd0);
    end
    run_op(3'd0, 0, 64'd6, 64'd9, 64'd54, 0);

    repeat (2) @(negedge clk);
    check("sb_left", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end
endmodule
